// File: rtl/fft_ram_arb_if.sv
// rtl/fft_ram_arb_if.sv - signal bundle between fft_ram_arb, its clients and the bin RAM
interface fft_ram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 28
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          det_start;
  logic          det_rd;
  logic [AW-1:0] det_addr;
  logic [DW-1:0] det_q;
  logic          det_qvalid;
  logic          det_done;
  logic          host_rd;
  logic [AW-1:0] host_addr;
  logic          host_wait;
  logic [DW-1:0] host_rdata;
  logic          host_rdvalid;
  logic          ram_wren;
  logic [AW-1:0] ram_wraddr;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_rdaddr;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          overrun;
  logic [7:0]    ovr_cnt;
  logic          det_timeout;

  modport master (
    input  wr_req, wr_addr, wr_data, frame_done, det_rd, det_addr, det_done,
           host_rd, host_addr, ram_q,
    output det_start, det_q, det_qvalid, host_wait, host_rdata, host_rdvalid,
           ram_wren, ram_wraddr, ram_data, ram_rdaddr, busy, overrun, ovr_cnt,
           det_timeout
  );

  modport slave (
    output wr_req, wr_addr, wr_data, frame_done, det_rd, det_addr, det_done,
           host_rd, host_addr, ram_q,
    input  det_start, det_q, det_qvalid, host_wait, host_rdata, host_rdvalid,
           ram_wren, ram_wraddr, ram_data, ram_rdaddr, busy, overrun, ovr_cnt,
           det_timeout
  );
endinterface

// File: rtl/fft_ram_arb.sv
// rtl/fft_ram_arb.sv - FFT bin buffer owner: FILL/DETECT sequencing and shared read-port arbitration
module fft_ram_arb #(
  parameter int AW          = 10,
  parameter int DW          = 28,
  parameter int RD_LAT      = 1,
  parameter int DET_TIMEOUT = 4096
) (
  input logic          clk,
  input logic          reset,
  fft_ram_arb_if.master bus
);

  typedef enum logic {FILL, DETECT} state_t;

  localparam logic [15:0] WD_LAST = 16'(DET_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [15:0]       wd_cnt;
  logic              det_start_r;
  logic              overrun_r;
  logic              det_timeout_r;
  logic [7:0]        ovr_r;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_det;

  logic              enter_det;
  logic              wd_expired;
  logic              wren;
  logic              hwait;
  logic              rd_acc;
  logic              rd_owner_det;
  logic [AW-1:0]     rdaddr;

  always_comb begin
    state_nx     = state;
    enter_det    = 1'b0;
    wd_expired   = 1'b0;
    wren         = 1'b0;
    hwait        = 1'b0;
    rd_acc       = 1'b0;
    rd_owner_det = 1'b0;
    rdaddr       = bus.host_addr;
    case (state)
      FILL: begin
        wren   = bus.wr_req;
        rd_acc = bus.host_rd;
        if (bus.frame_done) begin
          state_nx  = DETECT;
          enter_det = 1'b1;
        end
      end
      DETECT: begin
        // Detector owns the port outright; the host must hold its request
        hwait = bus.host_rd;
        if (bus.det_rd) begin
          rd_acc       = 1'b1;
          rd_owner_det = 1'b1;
          rdaddr       = bus.det_addr;
        end
        wd_expired = (wd_cnt == WD_LAST);
        if (bus.det_done || wd_expired) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FILL;
      wd_cnt        <= 16'd0;
      det_start_r   <= 1'b0;
      overrun_r     <= 1'b0;
      det_timeout_r <= 1'b0;
      ovr_r         <= 8'd0;
      tag_v         <= '0;
      tag_det       <= '0;
    end else begin
      state       <= state_nx;
      det_start_r <= enter_det;
      if (enter_det) begin
        wd_cnt <= 16'd0;
      end else if (state == DETECT) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (state == DETECT) begin
        if (bus.wr_req || bus.frame_done) begin
          overrun_r <= 1'b1;
        end
        if (bus.wr_req && (ovr_r != 8'hFF)) begin
          ovr_r <= ovr_r + 8'd1;
        end
        if (wd_expired && !bus.det_done) begin
          det_timeout_r <= 1'b1;
        end
      end
      // Owner tags ride alongside the RAM latency so data returns to its issuer
      tag_v[0]   <= rd_acc;
      tag_det[0] <= rd_owner_det;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_det[i] <= tag_det[i-1];
      end
    end
  end

  assign bus.ram_wren     = wren;
  assign bus.ram_wraddr   = bus.wr_addr;
  assign bus.ram_data     = bus.wr_data;
  assign bus.ram_rdaddr   = rdaddr;
  assign bus.host_wait    = hwait;
  assign bus.det_start    = det_start_r;
  assign bus.det_q        = bus.ram_q;
  assign bus.host_rdata   = bus.ram_q;
  assign bus.det_qvalid   = tag_v[RD_LAT-1] & tag_det[RD_LAT-1];
  assign bus.host_rdvalid = tag_v[RD_LAT-1] & ~tag_det[RD_LAT-1];
  assign bus.busy         = (state == DETECT);
  assign bus.overrun      = overrun_r;
  assign bus.ovr_cnt      = ovr_r;
  assign bus.det_timeout  = det_timeout_r;

endmodule

// File: tb/tb_fft_ram_arb.sv
// tb/tb_fft_ram_arb.sv - randomized scoreboard bench for fft_ram_arb
module tb_fft_ram_arb;

  localparam int AW     = 10;
  localparam int DW     = 28;
  localparam int RD_LAT = 2;
  localparam int TMO    = 64;
  localparam int DEPTH  = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  fft_ram_arb_if #(.AW(AW), .DW(DW)) bus ();

  fft_ram_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .DET_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bin RAM with RD_LAT cycles of read latency, old data on read-during-write
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] qpipe [RD_LAT];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    for (int i = 0; i < RD_LAT; i++) qpipe[i] = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_wren) ram[bus.ram_wraddr] <= bus.ram_data;
    qpipe[0] <= ram[bus.ram_rdaddr];
    for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
  end
  assign bus.ram_q = qpipe[RD_LAT-1];

  // Reference model
  logic [DW-1:0] ref_mem [DEPTH];
  exp_t det_exp[$];
  exp_t host_exp[$];
  bit   m_detect, m_start, m_overrun, m_tmo;
  int   m_dcyc, m_ovr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endfunction

  task automatic model_reset();
    m_detect = 0; m_start = 0; m_overrun = 0; m_tmo = 0; m_dcyc = 0; m_ovr = 0;
  endtask

  task automatic idle();
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.frame_done = 0;
    bus.det_rd = 0; bus.det_addr = '0; bus.det_done = 0;
    bus.host_rd = 0; bus.host_addr = '0;
  endtask

  // One clock cycle: check observable state, predict reads, advance the model
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("busy", 32'(bus.busy), 32'(m_detect));
    chk("det_start", 32'(bus.det_start), 32'(m_start));
    chk("host_wait", 32'(bus.host_wait), 32'(m_detect && bus.host_rd));
    chk("ram_wren", 32'(bus.ram_wren), 32'(!m_detect && bus.wr_req));
    if (!m_detect && bus.wr_req) begin
      chk("ram_wraddr", 32'(bus.ram_wraddr), 32'(bus.wr_addr));
      chk("ram_data", 32'(bus.ram_data), 32'(bus.wr_data));
    end
    chk("overrun", 32'(bus.overrun), 32'(m_overrun));
    chk("ovr_cnt", 32'(bus.ovr_cnt), 32'(m_ovr));
    chk("det_timeout", 32'(bus.det_timeout), 32'(m_tmo));
    if (m_detect && bus.det_rd) begin
      e.data = ref_mem[bus.det_addr]; e.cyc = cyc + RD_LAT;
      det_exp.push_back(e);
    end
    if (!m_detect && bus.host_rd) begin
      e.data = ref_mem[bus.host_addr]; e.cyc = cyc + RD_LAT;
      host_exp.push_back(e);
    end
    if (!m_detect) begin
      if (bus.wr_req) ref_mem[bus.wr_addr] = bus.wr_data;
      m_start = bus.frame_done;
      if (bus.frame_done) begin
        m_detect = 1; m_dcyc = 0;
      end
    end else begin
      m_start = 0;
      if (bus.wr_req || bus.frame_done) m_overrun = 1;
      if (bus.wr_req && m_ovr < 255) m_ovr++;
      m_dcyc++;
      if (bus.det_done) m_detect = 0;
      else if (m_dcyc == TMO) begin
        m_detect = 0; m_tmo = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid must match the oldest prediction, in data and timing
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.det_qvalid) begin
        if (det_exp.size() == 0) chk("det_unexpected", 32'(bus.det_qvalid), 32'd0);
        else begin
          e = det_exp.pop_front();
          chk("det_q", 32'(bus.det_q), 32'(e.data));
          chk("det_lat", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.host_rdvalid) begin
        if (host_exp.size() == 0) chk("host_unexpected", 32'(bus.host_rdvalid), 32'd0);
        else begin
          e = host_exp.pop_front();
          chk("host_rdata", 32'(bus.host_rdata), 32'(e.data));
          chk("host_lat", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();
    idle();
    reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    step();

    // Fill all bins with random host reads; frame_done lands on the last write
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_req = 1; bus.wr_addr = AW'(i);
      bus.wr_data = (i == 'hCC) ? DW'('hDDDD) : DW'('hAAAA);
      bus.host_rd = 1'($urandom_range(0, 1)); bus.host_addr = AW'($urandom);
      bus.frame_done = (i == DEPTH - 1);
      step();
    end
    idle();

    // Detection with contending host; detector also reads on its det_done cycle
    for (int k = 0; k < 20; k++) begin
      bus.host_rd = 1; bus.host_addr = AW'('h10);
      bus.det_rd = (k == 0 || k == 19) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.det_addr = (k == 0) ? AW'('hCC) : AW'($urandom);
      bus.wr_req = 1'($urandom_range(0, 1)); bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
      bus.det_done = (k == 19);
      step();
    end
    idle();
    bus.host_rd = 1; bus.host_addr = AW'('h10);
    step();
    idle();
    repeat (4) step();

    // Watchdog exits while writes keep arriving; drives ovr_cnt to saturation
    for (int p = 0; p < 5; p++) begin
      bus.frame_done = 1;
      step();
      idle();
      guard = 0;
      while (m_detect && guard < 200) begin
        bus.wr_req = 1; bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
        bus.det_rd = 1'($urandom_range(0, 1)); bus.det_addr = AW'($urandom);
        step();
        guard++;
      end
      chk("watchdog_cycles", 32'(guard), 32'(TMO));
      idle();
      step();
    end

    // det_done and frame_done together: back to FILL without restarting
    bus.frame_done = 1;
    step();
    idle();
    repeat (5) step();
    bus.det_done = 1; bus.frame_done = 1;
    step();
    idle();
    repeat (3) step();

    // RAM must be untouched by dropped writes
    bus.host_rd = 1; bus.host_addr = AW'('hCC);
    step();
    for (int i = 0; i < 64; i++) begin
      bus.host_addr = AW'($urandom);
      step();
    end
    idle();
    repeat (4) step();

    // Reset while a det_done-cycle read is in flight: it must vanish
    bus.frame_done = 1;
    step();
    idle();
    repeat (3) step();
    bus.det_done = 1; bus.det_rd = 1; bus.det_addr = AW'('hCC);
    step();
    idle();
    reset = 0;
    det_exp.delete();
    host_exp.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (6) step();

    chk("det_queue_drained", 32'(det_exp.size()), 32'd0);
    chk("host_queue_drained", 32'(host_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
